// File: rtl/controle_varredura.sv
// Four-digit 2-of-5 display scan controller: validated digit writes plus an OFF/SHOW/DARK
// multiplexing FSM driving shared segment decoders with active-low digit selects.
module controle_varredura #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned GAP      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_addr,
    input  logic [4:0] wr_code,
    input  logic       enable,
    input  logic       err_clr,
    output logic [4:0] code_out,
    output logic [3:0] digit_en,
    output logic       code_err
);

    localparam int unsigned MaxCnt = (PRESCALE > GAP) ? PRESCALE : GAP;
    localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

    typedef enum logic [1:0] {StOff, StShow, StDark} state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [3:0][4:0] digit_q;
    logic            chk_valid_q;
    logic [1:0]      chk_addr_q;
    logic [4:0]      chk_code_q;
    logic            wr_ready_q;
    logic            code_err_q, code_err_d;
    logic [3:0]      digit_en_q, digit_en_d;
    logic [4:0]      code_out_q, code_out_d;

    logic wr_accept;
    logic code_ok;

    assign wr_accept = wr_valid & wr_ready_q;
    assign code_ok   = ($countones(chk_code_q) == 2);

    // Set wins over clear so an error raised in the clearing cycle is not lost.
    always_comb begin
        code_err_d = code_err_q;
        if (err_clr) begin
            code_err_d = 1'b0;
        end
        if (chk_valid_q && !code_ok) begin
            code_err_d = 1'b1;
        end
    end

    // Write path: one accept cycle, one check cycle, then ready again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ready_q  <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_addr_q  <= 2'd0;
            chk_code_q  <= 5'd0;
            digit_q     <= '0;
            code_err_q  <= 1'b0;
        end else begin
            wr_ready_q  <= ~wr_accept;
            chk_valid_q <= wr_accept;
            if (wr_accept) begin
                chk_addr_q <= wr_addr;
                chk_code_q <= wr_code;
            end
            if (chk_valid_q) begin
                digit_q[chk_addr_q] <= code_ok ? chk_code_q : 5'b00000;
            end
            code_err_q <= code_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            StOff: begin
                idx_d = 2'd0;
                cnt_d = '0;
                if (enable) begin
                    state_d = StShow;
                end
            end
            StShow: begin
                if (!enable) begin
                    state_d = StOff;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(PRESCALE - 1)) begin
                    state_d = StDark;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDark: begin
                if (!enable) begin
                    state_d = StOff;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(GAP - 1)) begin
                    state_d = StShow;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StOff;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers match the state they enter.
    always_comb begin
        digit_en_d = 4'b1111;
        code_out_d = 5'b00000;
        if (state_d == StShow) begin
            digit_en_d = ~(4'b0001 << idx_d);
            code_out_d = digit_q[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StOff;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            digit_en_q <= 4'b1111;
            code_out_q <= 5'b00000;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            digit_en_q <= digit_en_d;
            code_out_q <= code_out_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign digit_en = digit_en_q;
    assign code_out = code_out_q;
    assign code_err = code_err_q;

endmodule

// File: tb/tb_controle_varredura.sv
// Directed bench for controle_varredura with PRESCALE=4, GAP=1 (5-cycle scan slots).
module tb_controle_varredura;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned GAP      = 1;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_addr  = 2'd0;
    logic [4:0] wr_code  = 5'd0;
    logic       enable   = 1'b0;
    logic       err_clr  = 1'b0;
    logic       wr_ready;
    logic [4:0] code_out;
    logic [3:0] digit_en;
    logic       code_err;

    int checks = 0;
    int errors = 0;

    controle_varredura #(
        .PRESCALE(PRESCALE),
        .GAP     (GAP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr (wr_addr),
        .wr_code (wr_code),
        .enable  (enable),
        .err_clr (err_clr),
        .code_out(code_out),
        .digit_en(digit_en),
        .code_err(code_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_digit(input logic [1:0] a, input logic [4:0] c);
        int n;
        n = 0;
        while (wr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_wait: wr_ready=%b expected 1", wr_ready);
        end
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_code  = c;
        tick();
        wr_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks += 4;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready);
        end
        if (digit_en !== 4'b1111) begin
            errors++; $display("FAIL reset_digit_en: got %b expected 1111", digit_en);
        end
        if (code_out !== 5'b00000) begin
            errors++; $display("FAIL reset_code_out: got %b expected 00000", code_out);
        end
        if (code_err !== 1'b0) begin
            errors++; $display("FAIL reset_code_err: got %b expected 0", code_err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL release_wr_ready_low: got %b expected 0", wr_ready);
        end
        tick();
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL release_wr_ready_high: got %b expected 1", wr_ready);
        end
    endtask

    task automatic test_code_err();
        wr_valid = 1'b1;
        wr_addr  = 2'd2;
        wr_code  = 5'b11100;
        tick();
        wr_valid = 1'b0;
        checks += 2;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL check_busy: wr_ready=%b expected 0", wr_ready);
        end
        if (code_err !== 1'b0) begin
            errors++; $display("FAIL err_early: code_err=%b expected 0", code_err);
        end
        tick();
        checks += 2;
        if (code_err !== 1'b1) begin
            errors++; $display("FAIL err_set: code_err=%b expected 1", code_err);
        end
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL ready_again: wr_ready=%b expected 1", wr_ready);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (code_err !== 1'b0) begin
            errors++; $display("FAIL err_clear: code_err=%b expected 0", code_err);
        end
        wr_valid = 1'b1;
        wr_addr  = 2'd3;
        wr_code  = 5'b11111;
        tick();
        wr_valid = 1'b0;
        err_clr  = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (code_err !== 1'b1) begin
            errors++; $display("FAIL err_set_wins: code_err=%b expected 1", code_err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (code_err !== 1'b0) begin
            errors++; $display("FAIL err_clear2: code_err=%b expected 0", code_err);
        end
    endtask

    task automatic test_scan();
        logic [4:0] exp_code [4];
        logic [3:0] exp_en;
        int idx;
        exp_code = '{5'b11000, 5'b00011, 5'b00000, 5'b01010};
        write_digit(2'd0, 5'b11000);
        write_digit(2'd1, 5'b00011);
        write_digit(2'd3, 5'b01010);
        enable = 1'b1;
        for (int s = 0; s < 5; s++) begin
            idx         = s % 4;
            exp_en      = 4'b1111;
            exp_en[idx] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                tick();
                checks += 2;
                if (digit_en !== exp_en) begin
                    errors++;
                    $display("FAIL scan_en s%0d c%0d: got %b expected %b", s, k, digit_en, exp_en);
                end
                if (code_out !== exp_code[idx]) begin
                    errors++;
                    $display("FAIL scan_code s%0d c%0d: got %b expected %b", s, k, code_out,
                             exp_code[idx]);
                end
            end
            tick();
            checks += 2;
            if (digit_en !== 4'b1111) begin
                errors++; $display("FAIL scan_dark_en s%0d: got %b expected 1111", s, digit_en);
            end
            if (code_out !== 5'b00000) begin
                errors++; $display("FAIL scan_dark_code s%0d: got %b expected 00000", s, code_out);
            end
        end
        enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] addr_seq [6];
        logic [4:0] code_seq [6];
        logic       rdy_seq  [6];
        logic [4:0] exp_code [4];
        logic [3:0] exp_en;
        addr_seq = '{2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd3};
        code_seq = '{5'b10001, 5'b11000, 5'b00110, 5'b11000, 5'b10100, 5'b11000};
        rdy_seq  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_code = '{5'b10001, 5'b00110, 5'b10100, 5'b01010};
        wr_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wr_addr = addr_seq[k];
            wr_code = code_seq[k];
            checks++;
            if (wr_ready !== rdy_seq[k]) begin
                errors++;
                $display("FAIL b2b_ready c%0d: got %b expected %b", k, wr_ready, rdy_seq[k]);
            end
            tick();
        end
        wr_valid = 1'b0;
        tick();
        enable = 1'b1;
        for (int s = 0; s < 4; s++) begin
            exp_en    = 4'b1111;
            exp_en[s] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++;
                if (digit_en !== exp_en || code_out !== exp_code[s]) begin
                    errors++;
                    $display("FAIL b2b_scan s%0d c%0d: got %b/%b expected %b/%b", s, k, digit_en,
                             code_out, exp_en, exp_code[s]);
                end
            end
            tick();
        end
        checks++;
        if (code_err !== 1'b0) begin
            errors++; $display("FAIL b2b_no_err: code_err=%b expected 0", code_err);
        end
        enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_live_update();
        logic [3:0] exp_en   [6];
        logic [4:0] exp_code [6];
        exp_en   = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101};
        exp_code = '{5'b10001, 5'b10001, 5'b00101, 5'b00101, 5'b00000, 5'b00110};
        enable   = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 2'd0;
        wr_code  = 5'b00101;
        for (int k = 0; k < 6; k++) begin
            tick();
            wr_valid = 1'b0;
            checks += 2;
            if (digit_en !== exp_en[k]) begin
                errors++;
                $display("FAIL live_en c%0d: got %b expected %b", k, digit_en, exp_en[k]);
            end
            if (code_out !== exp_code[k]) begin
                errors++;
                $display("FAIL live_code c%0d: got %b expected %b", k, code_out, exp_code[k]);
            end
        end
        enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_disable_and_reset();
        logic [3:0] exp_en;
        enable = 1'b1;
        for (int k = 0; k < 11; k++) begin
            tick();
        end
        checks++;
        if (digit_en !== 4'b1011 || code_out !== 5'b10100) begin
            errors++;
            $display("FAIL dis_at_idx2: got %b/%b expected 1011/10100", digit_en, code_out);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (digit_en !== 4'b1111 || code_out !== 5'b00000) begin
            errors++;
            $display("FAIL dis_off: got %b/%b expected 1111/00000", digit_en, code_out);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (digit_en !== 4'b1110 || code_out !== 5'b00101) begin
            errors++;
            $display("FAIL dis_restart: got %b/%b expected 1110/00101", digit_en, code_out);
        end
        wr_valid = 1'b1;
        wr_addr  = 2'd1;
        wr_code  = 5'b00000;
        tick();
        wr_valid = 1'b0;
        tick();
        checks++;
        if (code_err !== 1'b1) begin
            errors++; $display("FAIL dis_err_set: code_err=%b expected 1", code_err);
        end
        wr_valid = 1'b1;
        wr_addr  = 2'd2;
        wr_code  = 5'b10010;
        tick();
        wr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b0 || digit_en !== 4'b1111 || code_out !== 5'b00000 ||
            code_err !== 1'b0) begin
            errors++;
            $display("FAIL midscan_reset: got rdy=%b en=%b code=%b err=%b expected 0/1111/00000/0",
                     wr_ready, digit_en, code_out, code_err);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            exp_en    = 4'b1111;
            exp_en[s] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++;
                if (digit_en !== exp_en || code_out !== 5'b00000) begin
                    errors++;
                    $display("FAIL post_reset s%0d c%0d: got %b/%b expected %b/00000", s, k,
                             digit_en, code_out, exp_en);
                end
            end
            tick();
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_ready: got %b expected 1", wr_ready);
        end
        enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_code_err();
        test_scan();
        test_back_to_back();
        test_live_update();
        test_disable_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/controle_varredura.md
CONTROLE_VARREDURA -- requirements
Module: controle_varredura

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000: clock cycles each digit is lit per scan slot (legal range >=2).
REQ-002 SHALL have parameter GAP, default 8: all-dark cycles between slots for anti-ghosting (legal range >=1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  write request for one digit register.
REQ-006 SHALL have port wr_ready  output  1  controller can accept a write this cycle.
REQ-007 SHALL have port wr_addr  input  2  digit index 0..3 being written.
REQ-008 SHALL have port wr_code  input  5  2-of-5 code; bit4=E1 ... bit0=E5.
REQ-009 SHALL have port enable  input  1  scan enable.
REQ-010 SHALL have port err_clr  input  1  clears code_err.
REQ-011 SHALL have port code_out  output  5  code driven to the shared segment decoders (bit4=E1).
REQ-012 SHALL have port digit_en  output  4  active-low one-hot digit select; bit n selects digit n.
REQ-013 SHALL have port code_err  output  1  sticky flag: an invalid code was written.

Function
REQ-014 SHALL hold four 5-bit digit registers, each reset to 5'b00000 (blank: no segment decodes).
REQ-015 SHALL accept a write on a rising edge where wr_valid=1 and wr_ready=1, capturing wr_addr/wr_code into a check stage.
REQ-016 SHALL deassert wr_ready in the cycle after an accepted write (check stage busy) and reassert it the following cycle, giving a maximum rate of one write per 2 cycles.
REQ-017 SHALL, in the check cycle, store wr_code into the addressed digit if exactly two bits are 1, else store 5'b00000 and set code_err.
REQ-018 SHALL keep wr_valid/wr_addr/wr_code ignored while wr_ready=0; no write is queued.
REQ-019 SHALL implement scan FSM states OFF, SHOW, DARK with a 2-bit index idx and a cycle counter sized for max(PRESCALE,GAP).
REQ-020 OFF: digit_en=4'b1111, code_out=5'b00000, idx=0; enable=1 -> SHOW with idx=0, counter=0.
REQ-021 SHOW: digit_en has bit idx low only, code_out = digit register idx; after PRESCALE cycles in SHOW -> DARK.
REQ-022 DARK: digit_en=4'b1111, code_out=5'b00000; after GAP cycles -> SHOW with idx=(idx+1) mod 4 (3 wraps to 0).
REQ-023 enable=0 in SHOW or DARK SHALL force OFF on the next edge, resetting idx and the counter.
REQ-024 digit_en and code_out SHALL be registered outputs that reflect the current state.
REQ-025 A store to the digit currently shown SHALL appear on code_out on the edge after the store, without leaving SHOW or restarting the counter.
REQ-026 code_err SHALL be cleared by err_clr=1; if set and clear occur in the same cycle, set wins.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force: FSM=OFF, idx=0, counter=0, all digit registers=5'b00000, check stage empty, wr_ready=0, digit_en=4'b1111, code_out=5'b00000, code_err=0.
REQ-028 wr_ready SHALL go to 1 on the first rising edge after rst_n goes to 1.
REQ-029 Reset asserted mid-write or mid-scan SHALL discard the pending write and the scan position.

Verification (PRESCALE=4, GAP=1)
REQ-030 Write addr0=11000, addr1=00011, enable=1 -> digit_en 1110 for 4 cycles with code_out 11000, 1 dark cycle at 1111/00000, then 1101 for 4 cycles with 00011.
REQ-031 Write addr2=11100 -> code_err=1 one cycle after the check, digit2 shows 00000; err_clr together with a new invalid write in the same cycle leaves code_err=1.
REQ-032 Scan through idx=3 -> after its DARK cycle, digit_en=1110 (wrap to 0).
REQ-033 wr_valid held high for 6 cycles -> exactly 3 writes accepted, and wr_ready toggles 1,0,1,0,1,0.
REQ-034 Rewrite the shown digit 0 with 00101 while in SHOW -> code_out=00101 one edge after the store, and the slot still ends at cycle 4.
REQ-035 enable=0 during SHOW at idx=2 -> OFF next edge (digit_en=1111); re-enable -> restarts at idx=0. rst_n pulse mid-scan -> immediate reset values, and all digits read 00000 afterwards.
